// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: a 4-byte register window on split even/odd
// CPU byte banks, a small transmit FIFO and an 8N1 serializer with a 16-bit divisor.
module io_uart_tx #(
  parameter logic [15:0] IO_BASE    = 16'h0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] mem_write_addr_even,
  input  logic [14:0] mem_write_addr_odd,
  input  logic [7:0]  mem_write_data_even,
  input  logic [7:0]  mem_write_data_odd,
  input  logic        mem_write_en_even,
  input  logic        mem_write_en_odd,
  input  logic [14:0] mem_read_addr_even,
  input  logic [14:0] mem_read_addr_odd,
  output logic [7:0]  io_read_data_even,
  output logic [7:0]  io_read_data_odd,
  output logic        io_read_hit_even,
  output logic        io_read_hit_odd,
  output logic        txd
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_r, state_n;
  logic [15:0]       div_r;
  logic [15:0]       cnt_r, cnt_n;
  logic [2:0]        idx_r, idx_n;
  logic [7:0]        shift_r, shift_n;
  logic              txd_n;
  logic              overflow_r;
  logic [7:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic wr_hit_even_s, wr_hit_odd_s, rd_hit_even_s, rd_hit_odd_s;
  logic sel_tx_s, sel_divlo_s, sel_status_s, sel_divhi_s;
  logic push_s, drop_s, pop_s;
  logic busy_s, empty_s, full_s;
  logic [7:0] status_s;

  // A bank word address already carries byte-address bits [15:1]; bit 0 picks the register pair.
  assign wr_hit_even_s = (mem_write_addr_even[14:1] == IO_BASE[15:2]);
  assign wr_hit_odd_s  = (mem_write_addr_odd[14:1]  == IO_BASE[15:2]);
  assign rd_hit_even_s = (mem_read_addr_even[14:1]  == IO_BASE[15:2]);
  assign rd_hit_odd_s  = (mem_read_addr_odd[14:1]   == IO_BASE[15:2]);

  assign sel_tx_s     = mem_write_en_even && wr_hit_even_s && !mem_write_addr_even[0];
  assign sel_divlo_s  = mem_write_en_even && wr_hit_even_s &&  mem_write_addr_even[0];
  assign sel_status_s = mem_write_en_odd  && wr_hit_odd_s  && !mem_write_addr_odd[0];
  assign sel_divhi_s  = mem_write_en_odd  && wr_hit_odd_s  &&  mem_write_addr_odd[0];

  // A full FIFO still accepts a byte when the serializer frees a slot in the same cycle.
  assign push_s  = sel_tx_s && ((count_r < DEPTH_C) || pop_s);
  assign drop_s  = sel_tx_s && !((count_r < DEPTH_C) || pop_s);

  assign busy_s   = (state_r != ST_IDLE);
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign full_s   = (count_r == DEPTH_C);
  assign status_s = {4'b0000, overflow_r, busy_s, empty_s, full_s};

  // Serializer next-state: each bit lasts div_r+1 cycles, the divisor is sampled at every reload.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    txd_n   = txd;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        txd_n = 1'b1;
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_n = ST_START;
          cnt_n   = div_r;
          shift_n = fifo_mem_r[rd_ptr_r];
          txd_n   = 1'b0;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_r != 16'd0) begin
          cnt_n = cnt_r - 16'd1;
        end else begin
          cnt_n   = div_r;
          state_n = ST_DATA;
          idx_n   = 3'd0;
          txd_n   = shift_r[0];
          shift_n = {1'b0, shift_r[7:1]};
        end
      end
      ST_DATA: begin
        if (cnt_r != 16'd0) begin
          cnt_n = cnt_r - 16'd1;
        end else if (idx_r == 3'd7) begin
          cnt_n   = div_r;
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end else begin
          cnt_n   = div_r;
          idx_n   = idx_r + 3'd1;
          txd_n   = shift_r[0];
          shift_n = {1'b0, shift_r[7:1]};
        end
      end
      ST_STOP: begin
        if (cnt_r != 16'd0) begin
          cnt_n = cnt_r - 16'd1;
        end else begin
          state_n = ST_IDLE;
          txd_n   = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  // Control state, registers, FIFO pointers and registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r           <= ST_IDLE;
      cnt_r             <= 16'd0;
      idx_r             <= 3'd0;
      shift_r           <= 8'h00;
      txd               <= 1'b1;
      overflow_r        <= 1'b0;
      div_r             <= DIV_RESET;
      wr_ptr_r          <= {PTR_W{1'b0}};
      rd_ptr_r          <= {PTR_W{1'b0}};
      count_r           <= {CNT_W{1'b0}};
      io_read_hit_even  <= 1'b0;
      io_read_hit_odd   <= 1'b0;
      io_read_data_even <= 8'h00;
      io_read_data_odd  <= 8'h00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      txd     <= txd_n;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      // A dropped byte wins over a same-cycle STATUS clear so the loss is never hidden.
      if (drop_s)            overflow_r <= 1'b1;
      else if (sel_status_s) overflow_r <= 1'b0;
      if (sel_divlo_s) div_r[7:0]  <= mem_write_data_even;
      if (sel_divhi_s) div_r[15:8] <= mem_write_data_odd;
      io_read_hit_even  <= rd_hit_even_s;
      io_read_hit_odd   <= rd_hit_odd_s;
      io_read_data_even <= (rd_hit_even_s && mem_read_addr_even[0]) ? div_r[7:0] : 8'h00;
      io_read_data_odd  <= !rd_hit_odd_s ? 8'h00 :
                           (mem_read_addr_odd[0] ? div_r[15:8] : status_s);
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mem_write_data_even;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed plus randomized bench for io_uart_tx; txd is recorded per cycle and
// compared against frames computed from the byte queue and divisor.
module tb_io_uart_tx;
  localparam int HIST = 8192;
  localparam logic [14:0] A_TX = 15'h0000;  // even: TXDATA, odd: STATUS
  localparam logic [14:0] A_DV = 15'h0001;  // even: DIVLO,  odd: DIVHI

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] wae, wao, rae, rao;
  logic [7:0]  wde, wdo;
  logic        wee, weo;
  logic [7:0]  rde, rdo;
  logic        rhe, rho;
  logic        txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic txd_hist [HIST];
  logic [7:0] exp_q [$];

  io_uart_tx dut (
    .clk(clk), .reset(reset),
    .mem_write_addr_even(wae), .mem_write_addr_odd(wao),
    .mem_write_data_even(wde), .mem_write_data_odd(wdo),
    .mem_write_en_even(wee), .mem_write_en_odd(weo),
    .mem_read_addr_even(rae), .mem_read_addr_odd(rao),
    .io_read_data_even(rde), .io_read_data_odd(rdo),
    .io_read_hit_even(rhe), .io_read_hit_odd(rho),
    .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < HIST) txd_hist[cyc] <= txd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic wr2(input logic ee, input logic [14:0] ae, input logic [7:0] de,
                     input logic eo, input logic [14:0] ao, input logic [7:0] d_o);
    wee = ee; wae = ae; wde = de; weo = eo; wao = ao; wdo = d_o;
    @(negedge clk);
    wee = 1'b0; weo = 1'b0;
  endtask

  task automatic wr_tx(input logic [7:0] d);
    wr2(1'b1, A_TX, d, 1'b0, A_TX, 8'h00);
  endtask

  task automatic rd(input logic [14:0] ae, input logic [14:0] ao);
    rae = ae; rao = ao;
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Expected frame: start bit, 8 data bits LSB first, stop bit, each p cycles, one idle cycle between.
  task automatic chk_frames(input string tag, input int start, input int p);
    int n, base, bad, tail;
    logic [7:0] by;
    logic e;
    n = exp_q.size();
    wait_until(start + n * (10 * p + 1) + 10 * p + 2);
    chk({tag, "_lead"}, {15'd0, txd_hist[start - 1]}, 16'd1);
    for (int f = 0; f < n; f++) begin
      by = exp_q[f];
      base = start + f * (10 * p + 1);
      bad = 0;
      for (int k = 0; k <= 10 * p; k++) begin
        if (k / p == 0)       e = 1'b0;
        else if (k / p >= 9)  e = 1'b1;
        else                  e = by[k / p - 1];
        if (txd_hist[base + k] !== e) bad++;
      end
      chk({tag, "_frame"}, 16'(bad), 16'd0);
    end
    tail = 0;
    for (int i = start + n * (10 * p + 1); i < start + n * (10 * p + 1) + 10 * p; i++)
      if (txd_hist[i] !== 1'b1) tail++;
    chk({tag, "_tail"}, 16'(tail), 16'd0);
  endtask

  initial begin
    int c, s, div, lows;
    reset = 1'b0;
    wee = 1'b0; weo = 1'b0; wae = '0; wao = '0; wde = '0; wdo = '0;
    rae = 15'h0000; rao = 15'h0000;
    @(negedge clk);
    // Writes and reads during reset must be ignored / masked.
    wr2(1'b1, A_TX, 8'h3C, 1'b1, A_DV, 8'h55);
    wr2(1'b1, A_DV, 8'h55, 1'b0, A_TX, 8'h00);
    @(negedge clk);
    chk("rst_txd", {15'd0, txd}, 16'd1);
    chk("rst_hit", {14'd0, rhe, rho}, 16'd0);
    chk("rst_data", {rde, rdo}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    rd(A_DV, A_DV);
    chk("div_reset", {rdo, rde}, 16'd103);
    rd(A_TX, A_TX);
    chk("hits_w0", {14'd0, rhe, rho}, 16'd3);
    chk("txdata_rd", {8'd0, rde}, 16'h00);
    chk("status_idle", {8'd0, rdo}, 16'h02);
    rd(15'h2000, 15'h2000);
    chk("miss_4000", {14'd0, rhe, rho}, 16'd0);
    chk("rst_no_tx", {15'd0, txd_hist[cyc - 1]}, 16'd1);

    // Same-cycle DIVLO/DIVHI write, then a frame with 17-cycle bits.
    wr2(1'b1, A_DV, 8'h10, 1'b1, A_DV, 8'h00);
    rd(A_DV, A_DV);
    chk("div_rb", {rdo, rde}, 16'h0010);
    exp_q.delete();
    exp_q.push_back(8'($urandom));
    c = cyc;
    wr_tx(exp_q[0]);
    chk_frames("div17", c + 2, 17);

    // DIV=1, 8'hA5: 20-cycle frame.
    wr2(1'b1, A_DV, 8'h01, 1'b1, A_DV, 8'h00);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    c = cyc;
    wr_tx(8'hA5);
    chk_frames("a5", c + 2, 2);

    // Randomized rounds: random divisor, 4 random bytes queued back-to-back.
    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(4, 1);
      wr2(1'b1, A_DV, 8'(div), 1'b1, A_DV, 8'h00);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
      c = cyc;
      for (int i = 0; i < 4; i++) wr_tx(exp_q[i]);
      chk_frames("rand", c + 2, div + 1);
      rd(A_TX, A_TX);
      chk("rand_status", {8'd0, rdo}, 16'h02);
    end

    // Overflow: DIV=103, six back-to-back writes.
    wr2(1'b1, A_DV, 8'd103, 1'b1, A_DV, 8'h00);
    c = cyc;
    for (int i = 0; i < 6; i++) wr_tx(8'(8'h11 * (i + 1)));
    rd(A_TX, A_TX);
    chk("ovf_status", {8'd0, rdo}, 16'h0D);
    chk("ovf_first_pop", {15'd0, txd_hist[c + 2]}, 16'd0);
    wr2(1'b0, A_TX, 8'h00, 1'b1, A_TX, 8'h00);
    rd(A_TX, A_TX);
    chk("ovf_clear", {8'd0, rdo}, 16'h05);

    // Reset mid-frame at data bit 3 with two bytes queued.
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wr2(1'b1, A_DV, 8'h01, 1'b1, A_DV, 8'h00);
    c = cyc;
    wr_tx(8'h35);
    wr_tx(8'hC3);
    wr_tx(8'h5A);
    s = c + 2;
    wait_until(s + 8);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_txd", {15'd0, txd}, 16'd1);
    chk("abort_bit3", {15'd0, txd_hist[s + 8]}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    rd(A_TX, A_TX);
    chk("abort_status", {8'd0, rdo}, 16'h02);
    repeat (60) @(negedge clk);
    lows = 0;
    for (int i = s + 9; i < cyc; i++) if (txd_hist[i] !== 1'b1) lows++;
    chk("abort_quiet", 16'(lows), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
